// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 1-cycle-latency memory port between fetch and data, data-first with anti-starvation streak and atomic lock.
// Rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_wsize,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [1:0]        m_wsize,
  input  logic [31:0]       m_rdata
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [0:0] {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  lock_state_t       state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              i_pend_q, i_pend_d;
  logic              d_pend_q, d_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic gnt_i;
  logic gnt_d;
  logic lock_hold;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    lock_hold = (state_q == LOCKED) && d_lock;

    if (!resetn) begin
      state_d  = OPEN;
      streak_d = 4'd0;
      addr_d   = '0;
      wdata_d  = '0;
    end else if (lock_hold) begin
      // Atomic sequence owns the port; streak is frozen until release.
      gnt_d = d_req;
    end else begin
      if (i_req && (streak_q == STREAK_MAX)) begin
        gnt_i = 1'b1;
      end else if (d_req) begin
        gnt_d = 1'b1;
      end else if (i_req) begin
        gnt_i = 1'b1;
      end

      if (!i_req || gnt_i) begin
        streak_d = 4'd0;
      end else if (gnt_d) begin
        streak_d = streak_q + 4'd1;
      end

      // A streak-limit win leaves gnt_d low, so lock entry naturally retries later.
      state_d = (gnt_d && d_lock) ? LOCKED : OPEN;
    end

    if (gnt_i || gnt_d) begin
      addr_d  = gnt_i ? i_addr : d_addr;
      wdata_d = d_wdata;
    end

    i_pend_d = gnt_i;
    d_pend_d = gnt_d && !d_we;
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    streak_q <= streak_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    i_pend_q <= i_pend_d;
    d_pend_q <= d_pend_d;
  end

  assign i_gnt   = gnt_i;
  assign d_gnt   = gnt_d;
  assign m_addr  = addr_d;
  assign m_wdata = wdata_d;
  assign m_wsize = (gnt_d && d_we) ? d_wsize : 2'b00;

  // Gating with resetn kills a response whose grant preceded reset assertion.
  assign i_rvalid = resetn && i_pend_q;
  assign d_rvalid = resetn && d_pend_q;
  assign i_rdata  = i_rvalid ? m_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? m_rdata : 32'd0;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters:
REQ-001 The block SHALL take parameter ADDR_W, default 14, meaning the byte-address width of every address port.
REQ-002 The block SHALL take parameter MAX_STREAK, default 4, meaning the maximum number of consecutive data grants while an instruction request waits (range 1..15).

Ports:
REQ-003 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port i_req  in  1  instruction-fetch request.
REQ-006 The block SHALL have port i_addr  in  ADDR_W  fetch byte address.
REQ-007 The block SHALL have port i_gnt  out  1  fetch request accepted this cycle.
REQ-008 The block SHALL have port i_rvalid  out  1  i_rdata valid.
REQ-009 The block SHALL have port i_rdata  out  32  fetched word.
REQ-010 The block SHALL have port d_req  in  1  data request.
REQ-011 The block SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-012 The block SHALL have port d_addr  in  ADDR_W  data byte address.
REQ-013 The block SHALL have port d_wdata  in  32  store data.
REQ-014 The block SHALL have port d_wsize  in  2  store size: 01 byte, 10 half, 11 word.
REQ-015 The block SHALL have port d_lock  in  1  atomic sequence; holds the port for data.
REQ-016 The block SHALL have port d_gnt  out  1  data request accepted this cycle.
REQ-017 The block SHALL have port d_rvalid  out  1  d_rdata valid (loads only).
REQ-018 The block SHALL have port d_rdata  out  32  load data.
REQ-019 The block SHALL have port m_addr  out  ADDR_W  shared memory address.
REQ-020 The block SHALL have port m_wdata  out  32  shared memory write data.
REQ-021 The block SHALL have port m_wsize  out  2  write size; 00 = no write.
REQ-022 The block SHALL have port m_rdata  in  32  memory read data; fixed 1-cycle latency.

Function
REQ-023 Grants SHALL be combinational from the current requests and state; at most one of i_gnt/d_gnt is high per cycle, and a grant is issued only to an asserted request.
REQ-024 Handshake: a requester SHALL hold req, addr, we, wdata and wsize stable until the cycle its gnt is high; the transfer is that cycle.
REQ-025 In a grant cycle, m_addr SHALL equal the winner's address; m_wsize SHALL equal d_wsize for a data store and 00 otherwise; m_wdata SHALL equal d_wdata.
REQ-026 With no grant, m_wsize SHALL be 00, and m_addr/m_wdata SHALL hold their previous values.
REQ-027 Reads SHALL be pipelined with one new grant possible every cycle and no idle cycles between back-to-back grants.
REQ-028 A read granted in cycle N SHALL produce rvalid for the same requester in cycle N+1 only, with rdata = m_rdata in that cycle; stores SHALL produce no rvalid.
REQ-029 Priority: data SHALL win by default.
REQ-030 A 4-bit streak counter SHALL count consecutive data grants made while i_req is high.
REQ-031 When streak == MAX_STREAK and i_req is high, instruction SHALL win and streak SHALL clear to 0.
REQ-032 Streak SHALL clear on any instruction grant and on any cycle with i_req low.
REQ-033 Lock FSM: states OPEN and LOCKED.
REQ-034 OPEN->LOCKED SHALL occur on a data grant with d_lock = 1.
REQ-035 In LOCKED, i_gnt SHALL be 0, the streak rule SHALL be suspended, and streak SHALL hold.
REQ-036 LOCKED->OPEN SHALL occur on the first cycle d_lock = 0, and arbitration SHALL be normal in that same cycle.
REQ-037 Simultaneous events: a LOCKED entry and a streak limit in the same cycle SHALL resolve to the streak limit (instruction wins, no lock entry); lock entry retries on the next data grant.

Reset
REQ-038 While resetn = 0, i_gnt, d_gnt, i_rvalid and d_rvalid SHALL be 0, m_wsize SHALL be 00, streak SHALL be 0, FSM SHALL be OPEN, and m_addr, m_wdata, i_rdata and d_rdata SHALL be 0.
REQ-039 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.
REQ-040 The first grant after reset deasserts SHALL be possible in the first cycle with resetn = 1.

Verification
REQ-041 i_req only, i_addr 0x0, 0x4, 0x8 on consecutive cycles -> i_gnt 3 cycles; i_rvalid cycles 2-4 with the matching m_rdata words.
REQ-042 i_req and d_req both held high, d_we = 0, MAX_STREAK = 4 -> grant pattern D,D,D,D,I repeating; d_rvalid/i_rvalid follow one cycle later.
REQ-043 Store d_addr 0x10, d_wsize 01, d_wdata 0xAB -> m_wsize = 01 and m_addr = 0x10 in the grant cycle only; no d_rvalid; m_wsize 00 in the next cycle.
REQ-044 d_lock = 1 with data grant, then i_req high for 10 cycles while d_lock stays 1 -> i_gnt stays 0; d_lock drops -> i_gnt in that same cycle if d_req is low.
REQ-045 Load granted in cycle N with resetn = 0 in cycle N+1 -> d_rvalid = 0 in cycle N+1, all outputs at reset values; normal grant in the first cycle after release.
